// File: rtl/instr_encode.sv
// RV32I instruction encoder, two-stage valid/ready pipeline.
//
// S1 captures the request fields together with the immediate range check.
// S2 assembles the 32-bit word from the S1 fields. An illegal request
// delivers the canonical NOP (addi x0, x0, 0) with out_err set.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake
//   in_fmt               0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_op .. in_rs2      RV32I instruction fields
//   in_imm               signed byte immediate as the decoder reconstructs it
//   out_valid/out_ready  result handshake
//   out_instr, out_err   encoded word and illegal-request flag
//   err_count            saturating count of delivered illegal words
module instr_encode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam logic [2:0]  FmtR = 3'd0;
  localparam logic [2:0]  FmtI = 3'd1;
  localparam logic [2:0]  FmtS = 3'd2;
  localparam logic [2:0]  FmtB = 3'd3;
  localparam logic [2:0]  FmtU = 3'd4;
  localparam logic [2:0]  FmtJ = 3'd5;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  // S1 state
  logic        s1_valid_q;
  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_op_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [31:0] s1_imm_q;
  logic        s1_err_q;

  // S2 state
  logic        s2_valid_q;
  logic [31:0] s2_instr_q;
  logic        s2_err_q;
  logic [7:0]  err_count_q;

  logic s2_adv;
  logic s1_adv;
  logic in_illegal;
  logic [31:0] word;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Immediate must be representable in the format's encoded field.
  always_comb begin
    in_illegal = 1'b0;
    case (in_fmt)
      FmtR:       in_illegal = 1'b0;
      FmtI, FmtS: in_illegal = (in_imm[31:11] != {21{in_imm[11]}});
      FmtB:       in_illegal = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
      FmtU:       in_illegal = (in_imm[11:0] != 12'd0);
      FmtJ:       in_illegal = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
      default:    in_illegal = 1'b1;
    endcase
  end

  always_comb begin
    word = Nop;
    case (s1_fmt_q)
      FmtR: word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_op_q};
      FmtI: word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_op_q};
      FmtS: word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0], s1_op_q};
      FmtB: word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                    s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      FmtU: word = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      FmtJ: word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                    s1_rd_q, s1_op_q};
      default: word = Nop;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= 3'd0;
      s1_op_q     <= 7'd0;
      s1_funct3_q <= 3'd0;
      s1_funct7_q <= 7'd0;
      s1_rd_q     <= 5'd0;
      s1_rs1_q    <= 5'd0;
      s1_rs2_q    <= 5'd0;
      s1_imm_q    <= 32'd0;
      s1_err_q    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_fmt_q    <= in_fmt;
        s1_op_q     <= in_op;
        s1_funct3_q <= in_funct3;
        s1_funct7_q <= in_funct7;
        s1_rd_q     <= in_rd;
        s1_rs1_q    <= in_rs1;
        s1_rs2_q    <= in_rs2;
        s1_imm_q    <= in_imm;
        s1_err_q    <= in_illegal;
      end
    end
  end

  // Output word only changes when a new item moves in, so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= Nop;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= s1_err_q ? Nop : word;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else if (s2_valid_q && out_ready && s2_err_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encode.sv
// Bench for instr_encode: directed scenarios plus randomized traffic, all
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_instr_encode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_op;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_encode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_op     (in_op),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [32:0] exp_q[$];  // {err, instr}
  logic [7:0]  exp_cnt = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: legality from signed ranges, word from shifts and masks.
  function automatic logic [32:0] model(input logic [2:0] fmt, input logic [31:0] op,
                                        input logic [31:0] f3, input logic [31:0] f7,
                                        input logic [31:0] rd, input logic [31:0] rs1,
                                        input logic [31:0] rs2, input logic [31:0] imm);
    int          s;
    logic        bad;
    logic [31:0] w;
    s   = $signed(imm);
    bad = 1'b0;
    w   = 32'd0;
    case (fmt)
      3'd0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: begin
        bad = (s < -2048) || (s > 2047);
        w   = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd2: begin
        bad = (s < -2048) || (s > 2047);
        w   = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((imm & 32'h1F) << 7) | op;
      end
      3'd3: begin
        bad = (s < -4096) || (s > 4095) || ((imm & 32'd1) != 0);
        w   = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
            | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
            | (((imm >> 11) & 1) << 7) | op;
      end
      3'd4: begin
        bad = (imm % 4096) != 0;
        w   = imm | (rd << 7) | op;
      end
      3'd5: begin
        bad = (s < -1048576) || (s > 1048575) || ((imm & 32'd1) != 0);
        w   = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = 32'h0000_0013;
    return {bad, w};
  endfunction

  // One clock: observe handshakes before the edge, end at the next falling edge.
  task automatic tick();
    logic [32:0] e;
    #1;
    check("err_count", 32'(err_count), 32'(exp_cnt));
    if (in_valid && in_ready)
      exp_q.push_back(model(in_fmt, 32'(in_op), 32'(in_funct3), 32'(in_funct7), 32'(in_rd),
                            32'(in_rs1), 32'(in_rs2), in_imm));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr", out_instr, e[31:0]);
        check("err", 32'(out_err), 32'(e[32]));
        if (e[32] && exp_cnt != 8'hFF) exp_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_op     = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 8'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    rst_n    = 1'b0;
    out_ready = 1'b1;
    drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1, x2, 5 with exact two-cycle latency
    drive(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    #1 check("addi_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_instr", out_instr, 32'h0051_0093);
    check("addi_err", 32'(out_err), 32'd0);
    tick();

    // add then beq back-to-back
    drive(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    drive(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    tick();
    in_valid = 1'b0;
    check("add_instr", out_instr, 32'h0020_81B3);
    tick();
    check("beq_valid", 32'(out_valid), 32'd1);
    check("beq_instr", out_instr, 32'hFE00_0EE3);
    tick();

    // lui, then an out-of-range I immediate
    drive(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    tick();
    drive(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'h0000_0800);
    tick();
    in_valid = 1'b0;
    check("lui_instr", out_instr, 32'h1234_52B7);
    tick();
    check("bad_i_instr", out_instr, 32'h0000_0013);
    check("bad_i_err", 32'(out_err), 32'd1);
    tick();
    check("err_count_one", 32'(err_count), 32'd1);

    // Backpressure: three offered, two accepted, output held
    out_ready = 1'b0;
    drive(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5);
    tick();
    drive(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    drive(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    #1 check("stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("stall_in_ready2", 32'(in_ready), 32'd0);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_instr", out_instr, 32'h0051_0093);
    check("stall_queued", 32'(exp_q.size()), 32'd2);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("stall_second", out_instr, 32'h0020_81B3);
    tick();
    check("stall_third", out_instr, 32'h1234_52B7);
    tick();
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5);
    tick();
    drive(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    in_valid = 1'b0;
    #1 check("full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_instr", out_instr, 32'h0000_0013);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    exp_cnt = 8'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    drive(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_jal", out_instr, 32'h0010_00EF);
    tick();

    // Saturation with 260 illegal formats
    for (int i = 0; i < 260; i++) begin
      drive(3'd7, 7'(i), 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      tick();
    end
    drain("sat_drain");
    check("err_sat", 32'(err_count), 32'hFF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      drive(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), 32'd0);
      case ($urandom_range(0, 4))
        0: in_imm = r;
        1: in_imm = {{20{r[11]}}, r[11:0]};
        2: in_imm = {{19{r[12]}}, r[12:1], 1'b0};
        3: in_imm = {{11{r[20]}}, r[20:1], 1'b0};
        default: in_imm = {r[31:12], 12'd0};
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 SHALL provide clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL provide in_valid, input, 1, encode request present.
REQ-004 SHALL provide in_ready, output, 1, request accepted on a cycle where in_valid && in_ready.
REQ-005 SHALL provide in_fmt, input, 3, format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-006 SHALL provide in_op (7), in_funct3 (3), in_funct7 (7), in_rd (5), in_rs1 (5), in_rs2 (5), all inputs, RV32I fields.
REQ-007 SHALL provide in_imm, input, 32, immediate as a signed byte value (the value the decoder reconstructs).
REQ-008 SHALL provide out_valid, output, 1, encoded word present.
REQ-009 SHALL provide out_ready, input, 1, consumer takes the word on a cycle where out_valid && out_ready.
REQ-010 SHALL provide out_instr, output, 32, encoded RV32I instruction word.
REQ-011 SHALL provide out_err, output, 1, request was illegal and out_instr carries the substituted NOP.
REQ-012 SHALL provide err_count, output, 8, saturating count of illegal requests delivered.

Function
REQ-013 SHALL implement a two-stage pipeline:
- S1 registers the fields and the range-check result.
- S2 registers the assembled word and the error flag.
REQ-014 SHALL present a request accepted in cycle N at the output in cycle N+2 when no stall occurs.
REQ-015 SHALL advance S2 when !s2_valid || out_ready.
REQ-016 SHALL advance S1 when !s1_valid || S2 advances.
REQ-017 SHALL drive in_ready equal to the S1 advance condition, combinationally from out_ready.
REQ-018 SHALL sustain one word per cycle while out_ready=1.
REQ-019 SHALL hold out_instr and out_err stable while out_valid && !out_ready.
REQ-020 SHALL assemble fields as follows:
- Common to all formats: op at [6:0].
- R: funct7, rs2, rs1, funct3, rd.
- I: imm[11:0] at [31:20], rs1, funct3, rd.
- S: imm[11:5] at [31:25], rs2, rs1, funct3, imm[4:0] at [11:7].
- B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11].
- U: imm[31:12], rd.
- J: imm[20], imm[10:1], imm[11], imm[19:12], rd.
REQ-021 SHALL flag a request illegal when any of the following holds:
- I or S: in_imm is not the sign extension of bit 11.
- B: in_imm is not the sign extension of bit 12, or imm[0]=1.
- J: in_imm is not the sign extension of bit 20, or imm[0]=1.
- U: imm[11:0] != 0.
- in_fmt is 6 or 7.
REQ-022 SHALL, for an illegal request, output out_instr=32'h00000013 with out_err=1; fields unused by a format are ignored and never cause an error.
REQ-023 SHALL increment err_count when an out_err=1 word is transferred, and saturate at 8'hFF.
REQ-024 SHALL keep in-order delivery with no drop or duplication under any out_ready pattern.

Reset
REQ-025 SHALL, while rst_n=0, force the following regardless of clk:
- s1_valid=0, s2_valid=0, out_valid=0.
- out_instr=32'h00000013, out_err=0.
- err_count=0.
REQ-026 SHALL drive in_ready=1 during and after reset, since both stages are empty.
REQ-027 SHALL discard in-flight requests on reset mid-operation; the first valid output after release is the first request accepted after release.

Verification
REQ-028 SHALL cover: I-format addi (op=0010011, f3=000, rd=1, rs1=2, imm=5) -> out_instr=0x00510093 at N+2, out_err=0.
REQ-029 SHALL cover: R-format add (op=0110011, f7=0, f3=0, rd=3, rs1=1, rs2=2), then B-format beq (op=1100011, rs1=0, rs2=0, imm=0xFFFFFFFC) back-to-back -> 0x002081B3 then 0xFE000EE3 in consecutive cycles.
REQ-030 SHALL cover: U-format lui (op=0110111, rd=5, imm=0x12345000) -> 0x123452B7; then an I-format request with imm=0x800 -> 0x00000013, out_err=1, err_count=1.
REQ-031 SHALL cover: out_ready=0 with 3 requests offered -> 2 accepted, in_ready=0 thereafter, output word stable; then out_ready=1 -> all 3 words delivered in order.
REQ-032 SHALL cover: rst_n pulsed low with both stages full -> outputs at reset values immediately; no stale word appears after release.
REQ-033 SHALL cover: 260 illegal requests (fmt=7) -> err_count saturates at 0xFF.
